// File: rtl/weight_word_gen.sv
// Constant-weight word sequencer: streams every WIDTH-bit word with exactly N ones,
// in ascending order, stepping with Gosper's next-combination recurrence.
module weight_word_gen #(
  parameter int WIDTH = 16,
  parameter int CW    = 5,
  parameter int NW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    weight,
  input  logic             abort,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NW-1:0]    word_cnt
);

  localparam int SW = $clog2(WIDTH + 1) + 1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_last_pat;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [NW-1:0]    r_cnt;

  logic             w_bad_weight;
  logic             w_xfer;
  logic             w_is_last;
  logic [WIDTH:0]   w_mask;
  logic [CW-1:0]    w_shamt;
  logic [WIDTH:0]   w_pat;
  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_c;
  logic [WIDTH:0]   w_r;
  logic [WIDTH:0]   w_next;
  logic [SW-1:0]    w_ctz;
  logic             w_unused;

  assign w_bad_weight = (weight > CW'(WIDTH));
  assign w_xfer       = r_valid & word_ready;
  assign w_is_last    = (r_word == r_last_pat);

  // First word is the low N bits; the final word is that block moved to the top.
  assign w_mask  = ((WIDTH+1)'(1) << weight) - (WIDTH+1)'(1);
  assign w_shamt = CW'(WIDTH) - weight;
  assign w_pat   = w_mask << w_shamt;

  assign w_x = {1'b0, r_word};
  assign w_c = w_x & (-w_x);
  assign w_r = w_x + w_c;

  always_comb begin
    w_ctz = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (w_c[i]) w_ctz = SW'(i);
    end
  end

  assign w_next   = w_r | (((w_r ^ w_x) >> 2) >> w_ctz);
  assign w_unused = ^{w_next[WIDTH], w_pat[WIDTH], w_mask[WIDTH]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start && !w_bad_weight) w_state_next = S_EMIT;
      S_EMIT: if (abort || (w_xfer && w_is_last)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_last_pat <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad_weight) begin
              r_err <= 1'b1;
            end else begin
              r_word     <= w_mask[WIDTH-1:0];
              r_last_pat <= w_pat[WIDTH-1:0];
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_cnt      <= '0;
            end
          end
        end
        S_EMIT: begin
          // A transfer coinciding with abort is still counted.
          if (w_xfer) r_cnt <= r_cnt + NW'(1);
          if (abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (w_is_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_word <= w_next[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign last       = r_valid & w_is_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign word_cnt   = r_cnt;

endmodule

// File: tb/tb_weight_word_gen.sv
// Directed/randomized bench for weight_word_gen against an enumerate-and-filter reference.
module tb_weight_word_gen;

  localparam int WIDTH = 16;
  localparam int CW    = 5;
  localparam int NW    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CW-1:0]    weight;
  logic             abort;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             last;
  logic             busy;
  logic             done;
  logic             err;
  logic [NW-1:0]    word_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  weight_word_gen #(.WIDTH(WIDTH), .CW(CW), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight(weight), .abort(abort),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .last(last), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"},  word_out,   0);
    chk({tag, "_valid"}, word_valid, 0);
    chk({tag, "_last"},  last,       0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_done"},  done,       0);
    chk({tag, "_err"},   err,        0);
    chk({tag, "_cnt"},   word_cnt,   0);
  endtask

  // Reference: every value in numeric order whose popcount equals n.
  task automatic build_ref(input int n);
    logic [WIDTH-1:0] v;
    exp_q.delete();
    for (int i = 0; i < (1 << WIDTH); i++) begin
      v = i[WIDTH-1:0];
      if ($countones(v) == n) exp_q.push_back(v);
    end
  endtask

  task automatic run_seq(input int n, input int pct, input int hold_idx,
                         input int start_idx, input int abort_idx, input int rst_idx);
    int idx = 0;
    int cyc = 0;
    int hold = 0;
    int budget;
    bit finished = 0;
    bit xfer;
    build_ref(n);
    budget = exp_q.size() * 50 + 100;
    start  = 1'b1;
    weight = CW'(n);
    step();
    start = 1'b0;
    chk("first_valid", word_valid, 1);
    chk("first_busy",  busy,       1);
    chk("first_cnt",   word_cnt,   0);
    while (!finished && cyc < budget) begin
      chk("valid_held", word_valid, 1);
      chk("word",       word_out,   exp_q[idx]);
      chk("last",       last,       (idx == exp_q.size() - 1));
      chk("popcount",   $countones(word_out), n);
      chk("cnt",        word_cnt,   idx);
      $display("n=%0d idx=%0d word=%04h last=%0b cnt=%0d", n, idx, word_out, last, word_cnt);
      if (idx == rst_idx) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        #2;
        rst_n = 1'b1;
        step();
        chk_all_zero("postrst");
        return;
      end
      if (idx == abort_idx) begin
        abort      = 1'b1;
        word_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("abort_valid", word_valid, 0);
        chk("abort_busy",  busy,       0);
        chk("abort_last",  last,       0);
        chk("abort_done",  done,       0);
        chk("abort_cnt",   word_cnt,   abort_idx);
        step();
        chk("abort_done2", done,       0);
        return;
      end
      if (idx == start_idx) begin
        start  = 1'b1;
        weight = CW'(5);
      end
      if (idx == hold_idx && hold < 5) begin
        word_ready = 1'b0;
        hold++;
      end else begin
        word_ready = ($urandom_range(0, 99) < pct);
      end
      xfer = word_valid && word_ready;
      step();
      start = 1'b0;
      if (xfer) begin
        idx++;
        if (idx == exp_q.size()) finished = 1;
      end
      cyc++;
    end
    word_ready = 1'b0;
    if (!finished) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("done_pulse", done,       1);
    chk("end_valid",  word_valid, 0);
    chk("end_busy",   busy,       0);
    chk("end_cnt",    word_cnt,   exp_q.size());
    step();
    chk("done_once",  done,       0);
    chk("hold_cnt",   word_cnt,   exp_q.size());
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    weight     = '0;
    abort      = 1'b0;
    word_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_valid", word_valid, 0);

    run_seq(2, 100, -1, -1, -1, -1);
    run_seq(8, 70, -1, -1, -1, -1);
    run_seq(0, 100, -1, -1, -1, -1);
    run_seq(16, 50, -1, -1, -1, -1);

    start  = 1'b1;
    weight = CW'(17);
    step();
    start = 1'b0;
    chk("err_pulse", err,        1);
    chk("err_valid", word_valid, 0);
    chk("err_busy",  busy,       0);
    chk("err_done",  done,       0);
    step();
    chk("err_once",  err,        0);
    chk("err_valid2", word_valid, 0);
    chk("err_busy2", busy,       0);

    run_seq(3, 80, 1, 2, -1, -1);
    run_seq(4, 100, -1, -1, 10, -1);
    run_seq(4, 100, -1, -1, -1, 7);
    run_seq(1, 60, -1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
